seg7_scan_ctrl: RTL and testbench

- Consumer end of the 7-segment refresh chain. Takes the 10 kHz divided clock from the display divider and a small register interface from the RISC-V peripheral bus.
- Time-multiplexes up to 8 hex digits onto the shared segment lines and the per-digit anode lines.
- Frame-synchronous data shadowing prevents visible tearing.
- Sits between the peripheral bus decoder and the FPGA display pins.

---
 rtl/seg7_scan_ctrl_if.sv | 13 +
 rtl/seg7_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Register bus between the peripheral decoder and the 7-segment scan controller.
// Single-cycle write strobe; readback is combinational from the addressed register.
interface seg7_scan_ctrl_if;
  // Handshake: a write happens on each clock edge where we_i=1 (no ready, no stall);
  // rdata_o always reflects the register selected by addr_i with zero wait states.
  logic        we_i;
  logic        addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;

  modport master (output we_i, addr_i, wdata_i, input rdata_o);
  modport slave  (input we_i, addr_i, wdata_i, output rdata_o);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous DATA shadowing.
// Optional per-digit dimming is compiled in with `define SEG7_DIMMING_EN.
module seg7_scan_ctrl #(
  parameter int N_DIGITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic            clk_10MHz_i,
  input  logic            rst_i,
  input  logic            clk_10kHz_i,
  seg7_scan_ctrl_if.slave bus,
  output logic [7:0]      an_o,
  output logic [6:0]      seg_o,
  output logic            dp_o
);
  localparam logic [31:0] CTRL_MASK = 32'h07FF_FF01;
  localparam logic [2:0]  LAST_IDX  = 3'(N_DIGITS - 1);
  localparam logic [7:0]  AN_OFF    = {8{ACTIVE_LOW}};
  localparam logic [6:0]  SEG_OFF   = {7{ACTIVE_LOW}};

  logic        prev;
  logic        tick;
  logic        wrap;
  logic [2:0]  idx;
  logic [31:0] data_stage;
  logic [31:0] data_active;
  logic [31:0] ctrl;
  logic        data_wr;
  logic        ctrl_wr;
  logic        dim_ok;
  logic [3:0]  nibble;
  logic        show;
  logic [7:0]  an_nx;
  logic [6:0]  seg_nx;
  logic        dp_nx;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign data_wr     = bus.we_i & ~bus.addr_i;
  assign ctrl_wr     = bus.we_i &  bus.addr_i;
  assign tick        = clk_10kHz_i & ~prev;
  assign wrap        = tick && (idx == LAST_IDX);
  assign bus.rdata_o = bus.addr_i ? ctrl : data_stage;

  // prev resets low so a refresh clock already high at reset release yields a tick.
  always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
    if (rst_i) prev <= 1'b0;
    else       prev <= clk_10kHz_i;
  end

  always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
    if (rst_i)     idx <= 3'd0;
    else if (tick) idx <= wrap ? 3'd0 : idx + 3'd1;
  end

  always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
    if (rst_i) begin
      data_stage <= '0;
      ctrl       <= '0;
    end else begin
      if (data_wr) data_stage <= bus.wdata_i;
      if (ctrl_wr) ctrl       <= bus.wdata_i & CTRL_MASK;
    end
  end

  // Shadow copy at frame start; a write landing on the wrapping tick is forwarded.
  always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
    if (rst_i)     data_active <= '0;
    else if (wrap) data_active <= data_wr ? bus.wdata_i : data_stage;
  end

`ifdef SEG7_DIMMING_EN
  logic [10:0] slot;
  logic [10:0] dim_limit;

  always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
    if (rst_i)                slot <= 11'd0;
    else if (tick)            slot <= 11'd0;
    else if (slot != 11'h7FF) slot <= slot + 11'd1;
  end

  assign dim_limit = 11'(({8'd0, ctrl[26:24]} + 11'd1) * 11'd125);
  assign dim_ok    = (slot < dim_limit);
`else
  assign dim_ok = 1'b1;
`endif

  always_comb begin
    an_nx  = '0;
    seg_nx = '0;
    dp_nx  = 1'b0;
    nibble = data_active[{idx, 2'b00} +: 4];
    show   = ctrl[0] & ctrl[{2'b01, idx}] & dim_ok;
    if (show) begin
      an_nx[idx] = 1'b1;
      seg_nx     = hex7(nibble);
      dp_nx      = ctrl[{2'b10, idx}];
    end
  end

  // Registered, one-hot anode drive: no overlap between digits at transitions.
  always_ff @(posedge clk_10MHz_i or posedge rst_i) begin
    if (rst_i) begin
      an_o  <= AN_OFF;
      seg_o <= SEG_OFF;
      dp_o  <= ACTIVE_LOW;
    end else begin
      an_o  <= an_nx ^ AN_OFF;
      seg_o <= seg_nx ^ SEG_OFF;
      dp_o  <= dp_nx ^ ACTIVE_LOW;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: tick-counting reference model plus directed/random scenarios.
// Define SEG7_DIMMING_EN for the dimming scenario.
module tb_seg7_scan_ctrl;
  localparam int N_DIGITS = 8;
`ifdef SEG7_DIMMING_EN
  localparam logic [31:0] BRIGHT_FULL = 32'h0700_0000;
`else
  localparam logic [31:0] BRIGHT_FULL = 32'h0000_0000;
`endif
  localparam logic [31:0] CTRL_ON = 32'h0000_FF01 | BRIGHT_FULL;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slow = 1'b0;
  logic [7:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;

  always #50 clk = ~clk;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl dut (
    .clk_10MHz_i (clk),
    .rst_i       (rst),
    .clk_10kHz_i (slow),
    .bus         (bus),
    .an_o        (an_o),
    .seg_o       (seg_o),
    .dp_o        (dp_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // refresh clock generator state
  bit slow_run = 1'b0;
  int slow_cnt = 0;
  int half     = 500;

  // reference model: digit = ticks since reset mod N, frame data latched when ticks hits a multiple of N
  logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_ticks;
  bit          m_prev;
  logic [31:0] m_stage, m_active, m_ctrl;
  logic [15:0] exp_q[$];
  logic [15:0] exp_now = 16'hFFFF;
  int          md;
  logic [7:0]  m_an;
  logic [6:0]  m_sg;
  logic        m_dp;
  bit          m_wr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ticks  = 0;
      m_prev   = 1'b0;
      m_stage  = '0;
      m_active = '0;
      m_ctrl   = '0;
      exp_q.delete();
      exp_q.push_back(16'hFFFF);
    end else begin
      md   = m_ticks % N_DIGITS;
      m_an = '0;
      m_sg = '0;
      m_dp = 1'b0;
      if (m_ctrl[0] && m_ctrl[8 + md]) begin
        m_an = 8'(1 << md);
        m_sg = hex_tab[m_active[4*md +: 4]];
        m_dp = m_ctrl[16 + md];
      end
      exp_q.push_back(~{m_an, m_sg, m_dp});
      m_wr = bus.we_i && !bus.addr_i;
      if (slow && !m_prev) begin
        m_ticks++;
        if (m_ticks % N_DIGITS == 0) m_active = m_wr ? bus.wdata_i : m_stage;
      end
      if (m_wr) m_stage = bus.wdata_i;
      if (bus.we_i && bus.addr_i) m_ctrl = bus.wdata_i & 32'h07FF_FF01;
      m_prev = slow;
    end
  end

  // driver: advance to the next falling edge, drop the write strobe, step the refresh clock
  task automatic adv(output bit rose);
    @(negedge clk);
    bus.we_i = 1'b0;
    rose = 1'b0;
    if (slow_run) begin
      if (slow_cnt >= half - 1) begin
        slow_cnt = 0;
        slow     = ~slow;
        rose     = slow;
      end else begin
        slow_cnt++;
      end
    end
    while (exp_q.size() > 0) exp_now = exp_q.pop_front();
  endtask

  task automatic bus_write(input logic a, input logic [31:0] d);
    bus.we_i    = 1'b1;
    bus.addr_i  = a;
    bus.wdata_i = d;
  endtask

  task automatic fresh_start(input int h);
    bit r;
    slow_run = 1'b0;
    slow     = 1'b0;
    rst      = 1'b1;
    adv(r);
    adv(r);
    rst      = 1'b0;
    half     = h;
    slow_cnt = 0;
    slow_run = 1'b1;
  endtask

  task automatic test_reset();
    bit r;
    half = 500; slow_cnt = 0; slow = 1'b0; slow_run = 1'b1;
    rst = 1'b1;
    bus.we_i = 1'b0; bus.addr_i = 1'b0; bus.wdata_i = '0;
    for (int i = 0; i < 1200; i++) begin
      adv(r);
      tests_run++;
      if ({an_o, seg_o, dp_o} !== 16'hFFFF) begin
        tests_failed++;
        $display("FAIL reset_hold cyc %0d: got %h want ffff", i, {an_o, seg_o, dp_o});
      end
    end
    bus.addr_i = 1'b0; #1;
    tests_run++;
    if (bus.rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata_data: got %h want 0", bus.rdata_o);
    end
    bus.addr_i = 1'b1; #1;
    tests_run++;
    if (bus.rdata_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata_ctrl: got %h want 0", bus.rdata_o);
    end
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      adv(r);
      tests_run++;
      if ({an_o, seg_o, dp_o} !== 16'hFFFF || exp_now !== 16'hFFFF) begin
        tests_failed++;
        $display("FAIL post_reset_idle cyc %0d: got %h model %h want ffff", i, {an_o, seg_o, dp_o}, exp_now);
      end
    end
  endtask

  task automatic test_scan();
    bit r;
    int t = 0, since = 99;
    bit done = 1'b0;
    logic [7:0] an_before = 8'hFF;
    fresh_start(30);
    adv(r); bus_write(1'b0, 32'h7654_3210);
    adv(r); bus_write(1'b1, CTRL_ON);
    adv(r);
    bus.addr_i = 1'b0; #1;
    tests_run++;
    if (bus.rdata_o !== 32'h7654_3210) begin
      tests_failed++;
      $display("FAIL scan_rdata_data: got %h want 76543210", bus.rdata_o);
    end
    bus.addr_i = 1'b1; #1;
    tests_run++;
    if (bus.rdata_o !== CTRL_ON) begin
      tests_failed++;
      $display("FAIL scan_rdata_ctrl: got %h want %h", bus.rdata_o, CTRL_ON);
    end
    for (int c = 0; c < 3000 && !done; c++) begin
      adv(r);
      if (r) begin since = 0; t++; an_before = an_o; end
      else since++;
      tests_run++;
      if ({an_o, seg_o, dp_o} !== exp_now) begin
        tests_failed++;
        $display("FAIL scan_model cyc %0d: got %h want %h", c, {an_o, seg_o, dp_o}, exp_now);
      end
      if (since == 1) begin
        tests_run++;
        if (an_o !== an_before) begin
          tests_failed++;
          $display("FAIL scan_early_change tick %0d: got %h want %h", t, an_o, an_before);
        end
      end
      if (since == 2) begin
        tests_run++;
        if (an_o !== ~(8'(1 << (t % 8)))) begin
          tests_failed++;
          $display("FAIL scan_anode tick %0d: got %h want %h", t, an_o, ~(8'(1 << (t % 8))));
        end
        if (t == 8 || t == 13) begin
          tests_run++;
          if (seg_o !== ((t == 8) ? 7'h40 : 7'h12)) begin
            tests_failed++;
            $display("FAIL scan_seg tick %0d: got %h want %h", t, seg_o, (t == 8) ? 7'h40 : 7'h12);
          end
        end
        if (t == 17) done = 1'b1;
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL scan_timeout: got %0d ticks want 17", t);
    end
  endtask

  task automatic test_midframe_write();
    bit r;
    int since = 99, d;
    bit written = 1'b0, done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      adv(r);
      if (r) since = 0; else since++;
      tests_run++;
      if ({an_o, seg_o, dp_o} !== exp_now) begin
        tests_failed++;
        $display("FAIL midframe_model cyc %0d: got %h want %h", c, {an_o, seg_o, dp_o}, exp_now);
      end
      if (since == 2) begin
        d = m_ticks % N_DIGITS;
        if (!written && d == 3) begin
          bus_write(1'b0, 32'hFFFF_FFFF);
          written = 1'b1;
        end else if (written && d >= 4) begin
          tests_run++;
          if (seg_o !== ~hex_tab[d]) begin
            tests_failed++;
            $display("FAIL midframe_old_digit %0d: got %h want %h", d, seg_o, ~hex_tab[d]);
          end
        end else if (written && d == 0) begin
          tests_run++;
          if (seg_o !== 7'h0E) begin
            tests_failed++;
            $display("FAIL midframe_next_frame: got %h want 0e", seg_o);
          end
          done = 1'b1;
        end
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL midframe_timeout: got %0d want 1", done);
    end
  endtask

  task automatic test_wrap_write();
    bit r;
    int since = 99;
    bit written = 1'b0, done = 1'b0;
    logic [31:0] v;
    v = $urandom;
    v[3:0] = 4'($urandom_range(0, 14));
    for (int c = 0; c < 3000 && !done; c++) begin
      adv(r);
      if (r) begin
        since = 0;
        if (!written && (m_ticks + 1) % N_DIGITS == 0) begin
          bus_write(1'b0, v);
          written = 1'b1;
        end
      end else since++;
      tests_run++;
      if ({an_o, seg_o, dp_o} !== exp_now) begin
        tests_failed++;
        $display("FAIL wrap_model cyc %0d: got %h want %h", c, {an_o, seg_o, dp_o}, exp_now);
      end
      if (written && since == 2) begin
        tests_run++;
        if (an_o !== 8'hFE || seg_o !== ~hex_tab[v[3:0]]) begin
          tests_failed++;
          $display("FAIL wrap_bypass: got an %h seg %h want an fe seg %h", an_o, seg_o, ~hex_tab[v[3:0]]);
        end
        done = 1'b1;
      end
    end
    tests_run++;
    if (!done) begin
      tests_failed++;
      $display("FAIL wrap_timeout: got %0d want 1", done);
    end
  endtask

  task automatic test_ctrl();
    bit r;
    int since = 99, t = 0, d;
    adv(r); bus_write(1'b1, 32'h0005_0F01 | BRIGHT_FULL);
    for (int c = 0; c < 3000 && t < 10; c++) begin
      adv(r);
      if (r) begin since = 0; t++; end else since++;
      tests_run++;
      if ({an_o, seg_o, dp_o} !== exp_now) begin
        tests_failed++;
        $display("FAIL ctrl_model cyc %0d: got %h want %h", c, {an_o, seg_o, dp_o}, exp_now);
      end
      if (since == 2) begin
        d = m_ticks % N_DIGITS;
        tests_run++;
        if (an_o !== ((d < 4) ? ~(8'(1 << d)) : 8'hFF) || dp_o !== !(d == 0 || d == 2)) begin
          tests_failed++;
          $display("FAIL ctrl_mask_dp digit %0d: got an %h dp %b want an %h dp %b", d, an_o, dp_o,
                   (d < 4) ? ~(8'(1 << d)) : 8'hFF, !(d == 0 || d == 2));
        end
      end
    end
    tests_run++;
    if (t < 10) begin
      tests_failed++;
      $display("FAIL ctrl_timeout: got %0d ticks want 10", t);
    end
  endtask

  task automatic test_random();
    bit r;
    logic a;
    logic [31:0] w;
    for (int it = 0; it < 6; it++) begin
      half = $urandom_range(3, 40);
      for (int c = 0; c < 500; c++) begin
        adv(r);
        tests_run++;
        if ({an_o, seg_o, dp_o} !== exp_now) begin
          tests_failed++;
          $display("FAIL random_model it %0d cyc %0d: got %h want %h", it, c, {an_o, seg_o, dp_o}, exp_now);
        end
        if ($urandom_range(0, 7) == 0) begin
          a = 1'($urandom_range(0, 1));
          bus.addr_i = a; #1;
          tests_run++;
          if (bus.rdata_o !== (a ? m_ctrl : m_stage)) begin
            tests_failed++;
            $display("FAIL random_rdata addr %0d: got %h want %h", a, bus.rdata_o, a ? m_ctrl : m_stage);
          end
        end
        if ($urandom_range(0, 7) == 0) begin
          a = 1'($urandom_range(0, 1));
          w = $urandom;
          if (a) begin
            w = (w & ~32'h0700_0000) | BRIGHT_FULL;
            w[0] = ($urandom_range(0, 3) != 0);
          end
          bus_write(a, w);
        end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    bit r;
    bit hit = 1'b0;
    half = 20;
    adv(r); bus_write(1'b1, CTRL_ON);
    for (int c = 0; c < 200 && !hit; c++) begin
      adv(r);
      if (c > 3 && an_o !== 8'hFF) hit = 1'b1;
    end
    rst = 1'b1; #1;
    tests_run++;
    if (!hit || {an_o, seg_o, dp_o} !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL midscan_reset_async: got %h (lit %0d) want ffff", {an_o, seg_o, dp_o}, hit);
    end
    adv(r); adv(r);
    slow_run = 1'b0;
    slow     = 1'b1;
    rst      = 1'b0;
    adv(r);
    bus_write(1'b1, CTRL_ON);
    for (int c = 0; c < 4; c++) begin
      adv(r);
      tests_run++;
      if ({an_o, seg_o, dp_o} !== exp_now) begin
        tests_failed++;
        $display("FAIL midscan_restart_model cyc %0d: got %h want %h", c, {an_o, seg_o, dp_o}, exp_now);
      end
    end
    tests_run++;
    if (an_o !== 8'hFD) begin
      tests_failed++;
      $display("FAIL midscan_restart_index: got %h want fd", an_o);
    end
  endtask

`ifdef SEG7_DIMMING_EN
  task automatic test_dimming();
    bit r;
    int since = 0, t = 0, on_cnt = 0, first_on = -1;
    bit rst_done = 1'b0;
    fresh_start(600);
    adv(r); bus_write(1'b1, 32'h0100_FF01);
    for (int c = 0; c < 6000 && !rst_done; c++) begin
      adv(r);
      if (r) begin
        if (t >= 1) begin
          tests_run++;
          if (on_cnt !== 250 || first_on !== 2) begin
            tests_failed++;
            $display("FAIL dim_window tick %0d: got %0d cycles from %0d want 250 from 2", t, on_cnt, first_on);
          end
        end
        t++; since = 0; on_cnt = 0; first_on = -1;
      end else since++;
      if (t >= 1 && an_o !== 8'hFF) begin
        on_cnt++;
        if (first_on < 0) first_on = since;
      end
      if (t == 3 && since == 100) begin
        rst = 1'b1; #1;
        tests_run++;
        if ({an_o, seg_o, dp_o} !== 16'hFFFF) begin
          tests_failed++;
          $display("FAIL dim_reset_async: got %h want ffff", {an_o, seg_o, dp_o});
        end
        rst_done = 1'b1;
      end
    end
    tests_run++;
    if (!rst_done) begin
      tests_failed++;
      $display("FAIL dim_timeout: got %0d ticks want 3", t);
    end
    adv(r);
    rst = 1'b0;
  endtask
`endif

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_midframe_write();
    test_wrap_write();
    test_ctrl();
    test_random();
    test_reset_mid_scan();
`ifdef SEG7_DIMMING_EN
    test_dimming();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
